// File: rtl/uart_msg_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_msg_seq_if
//  Purpose  : Byte handshake between the message sequencer and the UART TX
//             stage. The byte and its valid flag travel downstream, and the
//             ready flag travels upstream.
//  Ports    : tx_data  [7:0]  ASCII byte offered to the UART TX stage
//             tx_valid        tx_data is valid and is held until accepted
//             tx_ready        UART TX can accept a byte this cycle
//  Modports : master (sequencer side), slave (UART TX side)
//  Revision : 1.0  initial release
// ============================================================================
interface uart_msg_seq_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface : uart_msg_seq_if
`default_nettype wire

// File: rtl/uart_msg_seq.sv
`default_nettype none
// ============================================================================
//  Module   : uart_msg_seq
//  Purpose  : Periodic ASCII banner generator that feeds a byte-level UART TX.
//             After an idle gap it sends one message, one byte at a time, over
//             a valid/ready handshake. It then waits for the next gap.
//  Config   : UART_MSG_COUNT_EN
//               defined   -> "HELLO " + 4 uppercase hex digits of a 16-bit
//                            message counter + CR LF  (12 bytes)
//               undefined -> "HELLO" + CR LF           (7 bytes, no counter)
//  Params   : CLOCK_RATE  clk frequency in Hz
//             GAP_MS      idle time between messages in ms
//  Ports    : clk       design clock
//             reset     synchronous, active-high reset
//             enable    1 = gap timer runs, 0 = no new message starts
//             tx        byte handshake (master modport of uart_msg_seq_if)
//             busy      1 while a message is being sent
//             msg_done  one-cycle pulse after the last byte is accepted
//  Revision : 1.0  initial release
// ============================================================================
module uart_msg_seq #(
  parameter int CLOCK_RATE = 1000,
  parameter int GAP_MS     = 1000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  uart_msg_seq_if.master tx,
  output logic           busy,
  output logic           msg_done
);

  // --------------------------------------------------------------------------
  // Gap timer sizing. The timer counts down from GAP_CYCLES-1 to 0. The message
  // starts on the enabled edge that finds it at 0, so the message begins on
  // the GAP_CYCLES-th enabled edge.
  // --------------------------------------------------------------------------
  localparam int GAP_RAW    = (CLOCK_RATE * GAP_MS) / 1000;
  localparam int GAP_CYCLES = (GAP_RAW < 1) ? 1 : GAP_RAW;
  localparam int TW         = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(GAP_CYCLES - 1);

`ifdef UART_MSG_COUNT_EN
  localparam int MSG_LEN = 12;
`else
  localparam int MSG_LEN = 7;
`endif
  localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

  typedef enum logic [0:0] {
    ST_GAP  = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t         state, state_n;
  logic [TW-1:0]  timer, timer_n;
  logic [3:0]     idx, idx_n;
  logic [7:0]     data_n;
  logic           valid_n;
  logic           busy_n;
  logic           done_n;
  logic           xfer;

`ifdef UART_MSG_COUNT_EN
  logic [15:0]    count, count_n;
  logic [15:0]    snap, snap_n;

  // Uppercase hex: 0-9 -> '0'..'9', A-F -> 'A'..'F' (8'h37 + n == 8'h41 + n-10).
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Message ROM. The digits come from the snapshot taken at message start.
  function automatic logic [7:0] msg_byte(input logic [3:0] i, input logic [15:0] s);
    logic [7:0] b;
    case (i)
      4'd0:    b = 8'h48;               // H
      4'd1:    b = 8'h45;               // E
      4'd2:    b = 8'h4C;               // L
      4'd3:    b = 8'h4C;               // L
      4'd4:    b = 8'h4F;               // O
      4'd5:    b = 8'h20;               // space
      4'd6:    b = hex_ascii(s[15:12]);
      4'd7:    b = hex_ascii(s[11:8]);
      4'd8:    b = hex_ascii(s[7:4]);
      4'd9:    b = hex_ascii(s[3:0]);
      4'd10:   b = 8'h0D;               // CR
      4'd11:   b = 8'h0A;               // LF
      default: b = 8'h00;
    endcase
    return b;
  endfunction
`else
  function automatic logic [7:0] msg_byte(input logic [3:0] i);
    logic [7:0] b;
    case (i)
      4'd0:    b = 8'h48;               // H
      4'd1:    b = 8'h45;               // E
      4'd2:    b = 8'h4C;               // L
      4'd3:    b = 8'h4C;               // L
      4'd4:    b = 8'h4F;               // O
      4'd5:    b = 8'h0D;               // CR
      4'd6:    b = 8'h0A;               // LF
      default: b = 8'h00;
    endcase
    return b;
  endfunction
`endif

  assign xfer = tx.tx_valid & tx.tx_ready;

  // --------------------------------------------------------------------------
  // Next-state and next-output logic. Every output is registered, so this
  // block computes the value each register takes at the next edge.
  // --------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    timer_n = timer;
    idx_n   = idx;
    data_n  = tx.tx_data;
    valid_n = tx.tx_valid;
    done_n  = 1'b0;
`ifdef UART_MSG_COUNT_EN
    count_n = count;
    snap_n  = snap;
`endif

    case (state)
      ST_GAP: begin
        valid_n = 1'b0;
        if (enable) begin
          if (timer != '0) begin
            timer_n = timer - TW'(1);
          end else begin
            state_n = ST_SEND;
            idx_n   = 4'd0;
            valid_n = 1'b1;
`ifdef UART_MSG_COUNT_EN
            snap_n  = count;
            data_n  = msg_byte(4'd0, count);
`else
            data_n  = msg_byte(4'd0);
`endif
          end
        end
      end

      ST_SEND: begin
        // enable is deliberately ignored here, so a started message always completes.
        if (xfer) begin
          if (idx == LAST_IDX) begin
            state_n = ST_GAP;
            valid_n = 1'b0;
            done_n  = 1'b1;
            timer_n = TIMER_RELOAD;
`ifdef UART_MSG_COUNT_EN
            count_n = count + 16'd1;
`endif
          end else begin
            // Load the next byte on the accepting edge, so transfers can run
            // back to back without a bubble.
            idx_n  = idx + 4'd1;
`ifdef UART_MSG_COUNT_EN
            data_n = msg_byte(idx + 4'd1, snap);
`else
            data_n = msg_byte(idx + 4'd1);
`endif
          end
        end
      end

      default: begin
        state_n = ST_GAP;
        valid_n = 1'b0;
        timer_n = TIMER_RELOAD;
      end
    endcase

    busy_n = (state_n == ST_SEND);
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_GAP;
      timer       <= TIMER_RELOAD;
      idx         <= 4'd0;
      tx.tx_data  <= 8'h00;
      tx.tx_valid <= 1'b0;
      busy        <= 1'b0;
      msg_done    <= 1'b0;
`ifdef UART_MSG_COUNT_EN
      count       <= 16'h0000;
      snap        <= 16'h0000;
`endif
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      idx         <= idx_n;
      tx.tx_data  <= data_n;
      tx.tx_valid <= valid_n;
      busy        <= busy_n;
      msg_done    <= done_n;
`ifdef UART_MSG_COUNT_EN
      count       <= count_n;
      snap        <= snap_n;
`endif
    end
  end

endmodule : uart_msg_seq
`default_nettype wire

// File: tb/tb_uart_msg_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_msg_seq
//  Purpose  : Self-checking bench for uart_msg_seq (CLOCK_RATE=1000, GAP_MS=5).
//             A reference model is advanced on each rising edge from the bench's
//             own inputs. It queues the expected bytes of every message that it
//             predicts, and it predicts valid/busy/msg_done. A monitor on the
//             falling edge compares the DUT against those predictions and pops
//             one expected byte for every accepted transfer.
//  Config   : UART_MSG_COUNT_EN selects the 12-byte message with a counter.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_msg_seq;
  localparam int GAP = 5;
`ifdef UART_MSG_COUNT_EN
  localparam int LEN = 12;
`else
  localparam int LEN = 7;
`endif

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic enable = 1'b0;
  logic rdy    = 1'b0;
  logic busy;
  logic msg_done;

  uart_msg_seq_if bus();
  assign bus.tx_ready = rdy;

  uart_msg_seq #(.CLOCK_RATE(1000), .GAP_MS(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .tx       (bus),
    .busy     (busy),
    .msg_done (msg_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sbq[$];
  bit  m_in = 0;
  int  m_pos = 0;
  int  m_gap = GAP;
  int  m_cnt = 0;
  bit  exp_valid = 0, exp_busy = 0, exp_done = 0, chk_on = 0;
  bit  rnd_rdy = 0, rnd_en = 0;
  int  dut_dones = 0;

  task automatic push_msg(input int c);
    sbq.push_back(8'h48); sbq.push_back(8'h45); sbq.push_back(8'h4C);
    sbq.push_back(8'h4C); sbq.push_back(8'h4F);
`ifdef UART_MSG_COUNT_EN
    sbq.push_back(8'h20);
    for (int d = 0; d < 4; d++) begin
      int nib;
      nib = (c >> (12 - 4 * d)) % 16;
      sbq.push_back(8'((nib < 10) ? (48 + nib) : (65 + nib - 10)));
    end
`endif
    sbq.push_back(8'h0D); sbq.push_back(8'h0A);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_in = 0; m_pos = 0; m_gap = GAP; m_cnt = 0; exp_done = 0;
      sbq.delete();
      chk_on = 1;
    end else begin
      exp_done = 0;
      if (!m_in) begin
        if (enable) begin
          m_gap--;
          if (m_gap == 0) begin
            m_in = 1; m_pos = 0;
            push_msg(m_cnt);
          end
        end
      end else if (rdy) begin
        m_pos++;
        if (m_pos == LEN) begin
          m_in = 0; exp_done = 1; m_gap = GAP;
          m_cnt = (m_cnt + 1) % 65536;
        end
      end
    end
    exp_valid = m_in;
    exp_busy  = m_in;
  end

  // ---------------- monitor ----------------
  bit         stall_prev = 0;
  logic [7:0] stall_data = 8'h00;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("tx_valid", {15'd0, bus.tx_valid}, {15'd0, exp_valid});
      chk("busy", {15'd0, busy}, {15'd0, exp_busy});
      chk("msg_done", {15'd0, msg_done}, {15'd0, exp_done});
      if (msg_done === 1'b1) dut_dones++;
      if (stall_prev) begin
        chk("stall_valid", {15'd0, bus.tx_valid}, 16'd1);
        chk("stall_data", {8'd0, bus.tx_data}, {8'd0, stall_data});
      end
      stall_prev = 0;
      if (bus.tx_valid === 1'b1 && rdy && !reset) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL byte: got %h, required no transfer (t=%0t)", bus.tx_data, $time);
        end else begin
          chk("byte", {8'd0, bus.tx_data}, {8'd0, sbq.pop_front()});
        end
      end else if (bus.tx_valid === 1'b1 && !rdy && !reset) begin
        stall_prev = 1;
        stall_data = bus.tx_data;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk); #2;
      if (rnd_rdy) rdy = ($urandom_range(0, 3) != 0);
      if (rnd_en)  enable = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic wait_msgs(input int k, input int budget, input string name);
    int target, t;
    target = dut_dones + k;
    t = 0;
    while (dut_dones < target && t < budget) begin cyc(1); t++; end
    n_cmp++;
    if (dut_dones < target) begin
      n_err++;
      $display("FAIL %s: got %0d msg_done pulses, required %0d within %0d cycles",
               name, dut_dones, target, budget);
    end
  endtask

  task automatic wait_pos(input int p, input int budget, input string name);
    int t;
    t = 0;
    while (!(m_in && m_pos == p) && t < budget) begin cyc(1); t++; end
    n_cmp++;
    if (!(m_in && m_pos == p)) begin
      n_err++;
      $display("FAIL %s: got timeout, required byte %0d offered within %0d cycles",
               name, p, budget);
    end
  endtask

  initial begin
    // 1. reset, then enable and ready held high
    reset = 1; enable = 1; rdy = 1;
    cyc(2);
    @(negedge clk);
    chk("rst_valid", {15'd0, bus.tx_valid}, 16'd0);
    chk("rst_data", {8'd0, bus.tx_data}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, msg_done}, 16'd0);
    @(posedge clk); #2;
    reset = 0;
    wait_msgs(2, 100, "t1_two_msgs");

    // 2. stall for 7 cycles while byte 2 is offered
    wait_pos(2, 100, "t2_reach_byte2");
    rdy = 0;
    cyc(7);
    rdy = 1;
    wait_msgs(1, 100, "t2_resume");

`ifdef UART_MSG_COUNT_EN
    // 3. counter wrap: FFFA..FFFF, then 0000
    cyc(1);
    force dut.count = 16'hFFFA;
    m_cnt = 'hFFFA;
    cyc(1);
    release dut.count;
    rnd_rdy = 1;
    wait_msgs(7, 600, "t3_wrap");
    rnd_rdy = 0; rdy = 1;
`endif

    // 4. enable low from reset, then a drop of enable in the middle of a message
    reset = 1; enable = 0;
    cyc(1);
    reset = 0;
    cyc(20);
    enable = 1;
    wait_pos(3, 100, "t4_start");
    enable = 0;
    wait_msgs(1, 100, "t4_complete");
    cyc(20);

    // 5. reset in the middle of a message
    enable = 1;
    wait_pos((LEN > 7) ? 7 : 5, 100, "t5_reach");
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_valid", {15'd0, bus.tx_valid}, 16'd0);
    chk("t5_busy", {15'd0, busy}, 16'd0);
`ifdef UART_MSG_COUNT_EN
    chk("t5_count", dut.count, 16'h0000);
`endif
    @(posedge clk); #2;
    reset = 0;
    wait_msgs(1, 100, "t5_restart");

    // 6. random enable and ready
    rnd_rdy = 1; rnd_en = 1;
    wait_msgs(5, 800, "t6_random");
    rnd_rdy = 0; rnd_en = 0; enable = 0; rdy = 1;
    cyc(3);
    chk("sb_empty", 16'(sbq.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule : tb_uart_msg_seq
`default_nettype wire
